// File: rtl/highest_level_service.sv
// In-service priority resolver: one-hot highest-priority level in service,
// honouring the special mask and rotating priority, registered with 1-cycle latency.
module highest_level_service (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] next_in_service_register,
    input  logic [7:0] interrupt_special_mask,
    input  logic [2:0] priority_rotate,
    output logic [7:0] highest_level_in_service
);

    localparam int unsigned LEVELS = 8;
    localparam int unsigned ROT_W  = 3;

    logic [LEVELS-1:0] masked;
    logic [LEVELS-1:0] rotated;
    logic [LEVELS-1:0] isolated;
    logic [LEVELS-1:0] restored;
    logic [ROT_W-1:0]  shift;

    function automatic logic [LEVELS-1:0] rotate_right(input logic [LEVELS-1:0] v,
                                                       input logic [ROT_W-1:0]  s);
        logic [2*LEVELS-1:0] d;
        d = {v, v} >> s;
        return d[LEVELS-1:0];
    endfunction

    function automatic logic [LEVELS-1:0] rotate_left(input logic [LEVELS-1:0] v,
                                                      input logic [ROT_W-1:0]  s);
        logic [2*LEVELS-1:0] d;
        d = {v, v} << s;
        return d[2*LEVELS-1:LEVELS];
    endfunction

    // Bring the highest-priority level to bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        masked   = next_in_service_register & ~interrupt_special_mask;
        shift    = priority_rotate + ROT_W'(1);
        rotated  = rotate_right(masked, shift);
        isolated = rotated & (~rotated + LEVELS'(1));
        restored = rotate_left(isolated, shift);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            highest_level_in_service <= '0;
        end else begin
            highest_level_in_service <= restored;
        end
    end

endmodule

// File: tb/tb_highest_level_service.sv
// Scoreboard bench for highest_level_service: stimulus pushes expected results,
// a monitor pops and compares one cycle later.
module tb_highest_level_service;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] next_in_service_register;
    logic [7:0] interrupt_special_mask;
    logic [2:0] priority_rotate;
    logic [7:0] highest_level_in_service;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    bit         stim_done = 1'b0;

    highest_level_service dut (
        .clock                    (clock),
        .reset                    (reset),
        .next_in_service_register (next_in_service_register),
        .interrupt_special_mask   (interrupt_special_mask),
        .priority_rotate          (priority_rotate),
        .highest_level_in_service (highest_level_in_service)
    );

    always #5 clock = ~clock;

    // Reference: walk levels in descending priority starting after the lowest one.
    function automatic logic [7:0] model(input logic [7:0] isr, input logic [7:0] mask,
                                         input logic [2:0] rot);
        logic [7:0] m;
        logic [7:0] r;
        int idx;
        m = isr & ~mask;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx = (int'(rot) + 1 + k) % 8;
            if (r == 8'h00 && m[idx]) r[idx] = 1'b1;
        end
        return r;
    endfunction

    task automatic apply(input logic r, input logic [7:0] isr, input logic [7:0] mask,
                         input logic [2:0] rot, input logic [7:0] expected, input string nm);
        reset                    = r;
        next_in_service_register = isr;
        interrupt_special_mask   = mask;
        priority_rotate          = rot;
        exp_q.push_back(expected);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    // Monitor: an item queued before this edge is due at the following negedge.
    initial begin
        int due;
        logic [7:0] e;
        string nm;
        forever begin
            @(posedge clock);
            due = exp_q.size();
            @(negedge clock);
            if (due > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (highest_level_in_service !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", nm, highest_level_in_service, e);
                end
                checks++;
                if (!$onehot0(highest_level_in_service)) begin
                    errors++;
                    $display("FAIL onehot0 after %s: got %h expected at most one bit",
                             nm, highest_level_in_service);
                end
            end
        end
    end

    initial begin
        logic [7:0] isr;
        logic [7:0] mask;
        // reset behaviour
        apply(1'b1, 8'hFF, 8'h00, 3'd7, 8'h00, "reset_cycle0");
        apply(1'b1, 8'hFF, 8'h00, 3'd7, 8'h00, "reset_cycle1");
        apply(1'b0, 8'hFF, 8'h00, 3'd7, 8'h01, "release_rot7");
        // directed priority cases
        apply(1'b0, 8'b0001_0100, 8'h00, 3'd7, 8'b0000_0100, "rot7_basic");
        apply(1'b0, 8'b0001_0100, 8'h00, 3'd2, 8'b0001_0000, "rot2_order");
        apply(1'b0, 8'b1000_0001, 8'h00, 3'd6, 8'b1000_0000, "rot6_wrap");
        apply(1'b0, 8'b0000_0110, 8'b0000_0010, 3'd7, 8'b0000_0100, "smm_partial");
        apply(1'b0, 8'b0000_0110, 8'b0000_0110, 3'd7, 8'h00, "smm_all");
        apply(1'b0, 8'h00, 8'h00, 3'd7, 8'h00, "isr_empty");
        apply(1'b0, 8'h01, 8'h00, 3'd0, 8'h01, "rot0_lowest_only");
        apply(1'b0, 8'h03, 8'h00, 3'd0, 8'h02, "rot0_ir1_high");
        apply(1'b0, 8'hFF, 8'h00, 3'd3, 8'h10, "rot3_full");
        apply(1'b0, 8'h41, 8'h00, 3'd5, 8'h40, "rot5_wrap");
        apply(1'b0, 8'h0F, 8'h08, 3'd4, 8'h01, "rot4_masked_wrap");
        // reset mid-operation, then first edge after release
        apply(1'b1, 8'hFF, 8'h00, 3'd7, 8'h00, "reset_mid");
        apply(1'b0, 8'h0C, 8'h00, 3'd1, 8'h04, "release_rot1");
        // rotate sweep with random ISR/mask against the reference model
        for (int rot = 0; rot < 8; rot++) begin
            for (int n = 0; n < 12; n++) begin
                isr  = 8'($urandom);
                mask = (n % 3 == 0) ? 8'h00 : 8'($urandom);
                apply(1'b0, isr, mask, 3'(rot), model(isr, mask, 3'(rot)), "sweep");
            end
        end
        stim_done = 1'b1;
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clock);
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
